i2c_csr_bridge: RTL and testbench

I2C_CSR_BRIDGE -- requirements
Module: i2c_csr_bridge

---
 rtl/i2c_csr_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_csr_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_csr_bridge.sv
`timescale 1ns/1ps
// i2c_csr_bridge
//   I2C target that maps bus transactions onto a small CSR bus. The first
//   byte after the address loads a 5-bit register pointer; further written
//   bytes produce csr_we strobes at the pointer (auto-increment). Reads
//   return csr_di at the pointer, incrementing on every master ACK.
//
//   Ports
//     clk            system clock
//     rst            asynchronous reset, active low
//     scl_in/sda_in  I2C pins, asynchronous to clk
//     sda_oe         1 pulls SDA low (open drain)
//     csr_a          CSR address (register pointer)
//     csr_do/csr_we  CSR write data / single-cycle write strobe
//     csr_di         CSR read data, combinational from csr_a
//
//   state    | meaning
//   IDLE     | ignore bus until START
//   ADDR     | shifting target address + R/W
//   ADDR_ACK | driving ACK for our address
//   REG      | shifting register pointer byte
//   REG_ACK  | driving ACK for pointer byte
//   WR       | shifting write data byte (and issuing csr_we)
//   WR_ACK   | driving ACK for data byte
//   RD       | driving read data bits
//   RD_ACK   | released SDA, sampling master ACK/NACK
module i2c_csr_bridge #(
   parameter logic [6:0] I2C_ADDR = 7'h4a
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [4:0] csr_a,
   output logic [7:0] csr_do,
   output logic       csr_we,
   input  logic [7:0] csr_di
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR, WR_ACK, RD, RD_ACK
   } state_t;

   logic   scl_s1_q, scl_s2_q, scl_h_q;
   logic   sda_s1_q, sda_s2_q, sda_h_q;
   state_t state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bcnt_q, bcnt_d;
   logic   rw_q, rw_d;
   logic   sda_oe_q, sda_oe_d;
   logic [4:0] ptr_q, ptr_d;
   logic [7:0] csr_do_q, csr_do_d;
   logic   csr_we_q, csr_we_d;
   logic   rd_more_q, rd_more_d;

   logic   start, stop, scl_rise, scl_fall;
   logic [7:0] byte_in;

   // Synchronisers reset to 1 so a released bus looks idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_h_q  <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_h_q  <= 1'b1;
      end else begin
         scl_s1_q <= scl_in;
         scl_s2_q <= scl_s1_q;
         scl_h_q  <= scl_s2_q;
         sda_s1_q <= sda_in;
         sda_s2_q <= sda_s1_q;
         sda_h_q  <= sda_s2_q;
      end
   end

   assign start    =  sda_h_q & ~sda_s2_q & scl_s2_q;
   assign stop     = ~sda_h_q &  sda_s2_q & scl_s2_q;
   assign scl_rise = ~scl_h_q &  scl_s2_q & ~start & ~stop;
   assign scl_fall =  scl_h_q & ~scl_s2_q & ~start & ~stop;
   assign byte_in  = {shift_q[6:0], sda_s2_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         bcnt_q    <= 3'd0;
         rw_q      <= 1'b0;
         sda_oe_q  <= 1'b0;
         ptr_q     <= 5'h00;
         csr_do_q  <= 8'h00;
         csr_we_q  <= 1'b0;
         rd_more_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bcnt_q    <= bcnt_d;
         rw_q      <= rw_d;
         sda_oe_q  <= sda_oe_d;
         ptr_q     <= ptr_d;
         csr_do_q  <= csr_do_d;
         csr_we_q  <= csr_we_d;
         rd_more_q <= rd_more_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bcnt_d    = bcnt_q;
      rw_d      = rw_q;
      sda_oe_d  = sda_oe_q;
      ptr_d     = ptr_q;
      csr_do_d  = csr_do_q;
      csr_we_d  = 1'b0;
      rd_more_d = rd_more_q;

      // Post-write increment lands one cycle after the strobe so csr_a
      // still shows the written address while csr_we is high.
      if (csr_we_q) ptr_d = ptr_q + 5'd1;

      if (start) begin
         state_d   = ADDR;
         bcnt_d    = 3'd0;
         sda_oe_d  = 1'b0;
         rd_more_d = 1'b0;
      end else if (stop) begin
         state_d   = IDLE;
         sda_oe_d  = 1'b0;
         rd_more_d = 1'b0;
      end else begin
         case (state_q)
            ADDR, REG: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) begin
                     if (state_q == REG) begin
                        ptr_d   = byte_in[4:0];
                        state_d = REG_ACK;
                     end else if (byte_in[7:1] == I2C_ADDR) begin
                        rw_d    = byte_in[0];
                        state_d = ADDR_ACK;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            WR: begin
               // Stay in WR for the strobe cycle, then open the ACK slot.
               if (csr_we_q) begin
                  state_d = WR_ACK;
               end else if (scl_rise) begin
                  shift_d = byte_in;
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) begin
                     csr_do_d = byte_in;
                     csr_we_d = 1'b1;
                  end
               end
            end
            ADDR_ACK, REG_ACK, WR_ACK: begin
               // First falling edge opens the slot, second closes it.
               if (scl_fall) begin
                  bcnt_d = 3'd0;
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     if (state_q == ADDR_ACK && rw_q) begin
                        shift_d  = csr_di;
                        sda_oe_d = ~csr_di[7];
                        state_d  = RD;
                     end else if (state_q == ADDR_ACK) begin
                        state_d = REG;
                     end else begin
                        state_d = WR;
                     end
                  end
               end
            end
            RD: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], 1'b1};
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) state_d = RD_ACK;
               end else if (scl_fall) begin
                  sda_oe_d = ~shift_q[7];
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     ptr_d     = ptr_q + 5'd1;
                     rd_more_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (scl_fall) begin
                  if (rd_more_q) begin
                     shift_d   = csr_di;
                     sda_oe_d  = ~csr_di[7];
                     rd_more_d = 1'b0;
                     bcnt_d    = 3'd0;
                     state_d   = RD;
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe = sda_oe_q;
   assign csr_a  = ptr_q;
   assign csr_do = csr_do_q;
   assign csr_we = csr_we_q;

endmodule

// File: tb/tb_i2c_csr_bridge.sv
`timescale 1ns/1ps
module tb_i2c_csr_bridge;

   localparam logic [6:0] DEV = 7'h4a;
   localparam time QT = 60ns;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic [4:0] csr_a;
   logic [7:0] csr_do;
   logic       csr_we;
   logic [7:0] csr_di;

   logic [7:0] per_regs [32];

   int checks = 0;
   int errors = 0;

   logic [12:0] log_a [1024];
   int          log_n = 0;
   int          rd_idx = 0;
   int          oe_cnt = 0;
   int          wide_cnt = 0;
   logic        prev_we = 1'b0;

   logic [12:0] exp_q [$];
   logic [7:0]  mdl_regs [32];
   logic [4:0]  mdl_ptr;
   logic [7:0]  wdat [8];

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;
   assign csr_di   = per_regs[csr_a];

   i2c_csr_bridge #(.I2C_ADDR(DEV)) dut (
      .clk    (clk),
      .rst    (rst),
      .scl_in (scl),
      .sda_in (sda_line),
      .sda_oe (sda_oe),
      .csr_a  (csr_a),
      .csr_do (csr_do),
      .csr_we (csr_we),
      .csr_di (csr_di)
   );

   always @(posedge clk) if (csr_we) per_regs[csr_a] <= csr_do;

   always @(negedge clk) begin
      if (csr_we && log_n < 1024) begin
         log_a[log_n] = {csr_a, csr_do};
         log_n = log_n + 1;
      end
      if (csr_we && prev_we) wide_cnt = wide_cnt + 1;
      prev_we = csr_we;
      if (sda_oe) oe_cnt = oe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic qt();
      #(QT);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; qt();
      scl = 1'b1;   qt();
      sda_m = 1'b0; qt();
      scl = 1'b0;   qt();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; qt();
      scl = 1'b1;   qt();
      sda_m = 1'b1; qt();
      qt();
   endtask

   task automatic wbit(input logic b);
      sda_m = b; qt();
      scl = 1'b1; qt();
      qt();
      scl = 1'b0; qt();
   endtask

   task automatic rbit(output logic b);
      sda_m = 1'b1; qt();
      scl = 1'b1; qt();
      b = sda_line; qt();
      scl = 1'b0; qt();
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(b);
      ack = ~b;
   endtask

   task automatic rbyte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(~ack);
   endtask

   task automatic check_log(input string tag);
      int got;
      logic [12:0] e;
      got = log_n - rd_idx;
      chk({tag, "_cnt"}, got, exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < log_n) begin
            chk({tag, "_ent"}, {19'd0, log_a[rd_idx]}, {19'd0, e});
            rd_idx++;
         end
      end
      rd_idx = log_n;
   endtask

   // Write transaction: address, pointer byte, n data bytes.
   task automatic do_write(input logic [6:0] a7, input logic [7:0] rg, input int n);
      logic ack;
      logic match;
      int   base_oe;
      match   = (a7 == DEV);
      base_oe = oe_cnt;
      i2c_start();
      wbyte({a7, 1'b0}, ack); chk("w_aack", ack, match);
      wbyte(rg, ack);         chk("w_rack", ack, match);
      if (match) mdl_ptr = rg[4:0];
      for (int i = 0; i < n; i++) begin
         wbyte(wdat[i], ack);
         chk("w_dack", ack, match);
         if (match) begin
            exp_q.push_back({mdl_ptr, wdat[i]});
            mdl_regs[mdl_ptr] = wdat[i];
            mdl_ptr = mdl_ptr + 5'd1;
         end
      end
      i2c_stop();
      repeat (4) @(negedge clk);
      check_log("w_log");
      chk("w_ptr", csr_a, mdl_ptr);
      if (!match) chk("w_oe", oe_cnt - base_oe, 0);
   endtask

   // Pointer write, repeated START, read n bytes (ACK all but last).
   task automatic do_read(input logic [7:0] rg, input int n);
      logic ack;
      logic [7:0] d;
      i2c_start();
      wbyte({DEV, 1'b0}, ack); chk("r_aack", ack, 1'b1);
      wbyte(rg, ack);          chk("r_rack", ack, 1'b1);
      mdl_ptr = rg[4:0];
      i2c_start();
      wbyte({DEV, 1'b1}, ack); chk("r_aack2", ack, 1'b1);
      for (int i = 0; i < n; i++) begin
         rbyte(d, i < n - 1);
         chk("r_data", d, mdl_regs[mdl_ptr]);
         if (i < n - 1) mdl_ptr = mdl_ptr + 5'd1;
      end
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("r_ptr", csr_a, mdl_ptr);
      check_log("r_log");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ack;
      logic [6:0] a7;
      logic [7:0] rg;
      int n, base_oe;

      rst = 1'b0; scl = 1'b1; sda_m = 1'b1;
      mdl_ptr = 5'h00;
      #23;
      chk("rst_oe", sda_oe, 1'b0);
      chk("rst_we", csr_we, 1'b0);
      chk("rst_a", csr_a, 5'h00);
      chk("rst_do", csr_do, 8'h00);
      @(negedge clk); rst = 1'b1;
      repeat (5) @(negedge clk);

      // Single write to register 2.
      wdat[0] = 8'h6b;
      do_write(DEV, 8'h02, 1);
      chk("wr_ptr3", csr_a, 5'h03);

      // Read with repeated START.
      wdat[0] = 8'hff; wdat[1] = 8'h00;
      do_write(DEV, 8'h01, 2);
      do_read(8'h01, 2);
      chk("rd_ptr2", csr_a, 5'h02);

      // Address mismatch.
      do_write(7'h4b, 8'h00, 0);

      // Pointer wrap.
      wdat[0] = 8'haa; wdat[1] = 8'h55;
      do_write(DEV, 8'h1f, 2);
      chk("wrap_ptr", csr_a, 5'h01);

      // Abort mid-byte, then bus activity without START is ignored.
      i2c_start();
      wbyte({DEV, 1'b0}, ack); chk("ab_aack", ack, 1'b1);
      wbyte(8'h00, ack);       chk("ab_rack", ack, 1'b1);
      mdl_ptr = 5'h00;
      for (int i = 0; i < 4; i++) wbit(1'($urandom_range(0, 1)));
      i2c_stop();
      repeat (4) @(negedge clk);
      check_log("ab_log");
      chk("ab_oe", sda_oe, 1'b0);
      base_oe = oe_cnt;
      wbyte({DEV, 1'b0}, ack); chk("ab_idle_ack", ack, 1'b0);
      i2c_stop();
      chk("ab_idle_oe", oe_cnt - base_oe, 0);
      chk("ab_ptr", csr_a, mdl_ptr);

      // Reset while driving read data.
      wdat[0] = 8'h3c;
      do_write(DEV, 8'h05, 1);
      i2c_start();
      wbyte({DEV, 1'b0}, ack);
      wbyte(8'h05, ack);
      i2c_start();
      wbyte({DEV, 1'b1}, ack); chk("rr_aack", ack, 1'b1);
      chk("rr_drive", sda_oe, 1'b1);
      rst = 1'b0;
      #1;
      chk("rr_rel", sda_oe, 1'b0);
      chk("rr_ptr", csr_a, 5'h00);
      mdl_ptr = 5'h00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      i2c_stop();
      wdat[0] = 8'($urandom); wdat[1] = 8'($urandom);
      do_write(DEV, 8'($urandom), 2);

      // Randomised transactions.
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            a7 = 7'($urandom);
            if (a7 == DEV) a7 = a7 ^ 7'h01;
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
            do_write(a7, 8'($urandom), n);
         end else begin
            rg = 8'($urandom);
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
            do_write(DEV, rg, n);
            do_read(rg, $urandom_range(1, n));
         end
      end

      chk("we_width", wide_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
